// File: rtl/led_pwm_breather.sv
// Breathing LED driver: turns the prescaler carry strobe into a triangle-ramped PWM level.
// Define LED_PWM_BREATHER_GAMMA_EN to square the level for a perceptual (gamma ~2) ramp.
//
// state     | meaning
// ----------+--------------------------------------------
// RAMP_UP   | level rises by one per applied step
// HOLD_HI   | level held at MAX for HOLD_STEPS steps
// RAMP_DOWN | level falls by one per applied step
// HOLD_LO   | level held at 0 for HOLD_STEPS steps
module led_pwm_breather #(
    parameter int PWM_BITS   = 8,
    parameter int STEP_DIV   = 4,
    parameter int HOLD_STEPS = 8,
    parameter int NUM_LEDS   = 5
) (
    input  logic                CLK,
    input  logic                RESETB,
    input  logic                TICK,
    input  logic                EN,
    output logic [NUM_LEDS-1:0] D,
    output logic [PWM_BITS-1:0] LEVEL,
    output logic                PHASE
);

    localparam int DIV_W  = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam int HOLD_W = (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS) : 1;
    localparam logic [PWM_BITS-1:0] MAX       = '1;
    localparam logic [DIV_W-1:0]    DIV_LAST  = DIV_W'(STEP_DIV - 1);
    localparam logic [HOLD_W-1:0]   HOLD_LAST = HOLD_W'(HOLD_STEPS - 1);

    typedef enum logic [1:0] {RAMP_UP, HOLD_HI, RAMP_DOWN, HOLD_LO} state_t;

    state_t              state, state_nxt;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [PWM_BITS-1:0] level_nxt;
    logic [PWM_BITS-1:0] duty_base;
    logic [DIV_W-1:0]    div_cnt;
    logic [HOLD_W-1:0]   hold_cnt, hold_nxt;
    logic                step_pending;
    logic                period_end;
    logic                div_wrap;
    logic                apply_step;

    assign period_end = EN && (pwm_cnt == MAX);
    assign div_wrap   = EN && TICK && (div_cnt == DIV_LAST);
    assign apply_step = period_end && step_pending;

    // Steps are only consumed at a period boundary so the duty never changes mid-period.
    always_ff @(posedge CLK or negedge RESETB) begin
        if (!RESETB) begin
            pwm_cnt      <= '0;
            div_cnt      <= '0;
            step_pending <= 1'b0;
        end else begin
            pwm_cnt <= EN ? pwm_cnt + 1'b1 : '0;
            if (EN && TICK) begin
                div_cnt <= div_wrap ? '0 : div_cnt + 1'b1;
            end
            if (apply_step) begin
                step_pending <= div_wrap;
            end else if (div_wrap) begin
                step_pending <= 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESETB) begin
        if (!RESETB) begin
            state    <= RAMP_UP;
            LEVEL    <= '0;
            hold_cnt <= '0;
        end else begin
            state    <= state_nxt;
            LEVEL    <= level_nxt;
            hold_cnt <= hold_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        level_nxt = LEVEL;
        hold_nxt  = hold_cnt;
        if (apply_step) begin
            case (state)
                RAMP_UP: begin
                    if (LEVEL != MAX) level_nxt = LEVEL + 1'b1;
                    if (level_nxt == MAX) begin
                        state_nxt = HOLD_HI;
                        hold_nxt  = '0;
                    end
                end
                HOLD_HI: begin
                    if (hold_cnt == HOLD_LAST) state_nxt = RAMP_DOWN;
                    else                       hold_nxt  = hold_cnt + 1'b1;
                end
                RAMP_DOWN: begin
                    if (LEVEL != '0) level_nxt = LEVEL - 1'b1;
                    if (level_nxt == '0) begin
                        state_nxt = HOLD_LO;
                        hold_nxt  = '0;
                    end
                end
                HOLD_LO: begin
                    if (hold_cnt == HOLD_LAST) state_nxt = RAMP_UP;
                    else                       hold_nxt  = hold_cnt + 1'b1;
                end
                default: state_nxt = RAMP_UP;
            endcase
        end
    end

    always_comb begin
        PHASE = (state == RAMP_UP) || (state == HOLD_HI);
    end

`ifdef LED_PWM_BREATHER_GAMMA_EN
    logic [2*PWM_BITS-1:0] level_sq;
    assign level_sq  = LEVEL * LEVEL;
    assign duty_base = PWM_BITS'(level_sq >> PWM_BITS);
`else
    assign duty_base = LEVEL;
`endif

    // LED i runs at half the duty of LED i-1.
    always_ff @(posedge CLK or negedge RESETB) begin
        if (!RESETB) begin
            D <= '0;
        end else begin
            for (int i = 0; i < NUM_LEDS; i++) begin
                D[i] <= EN && (pwm_cnt < (duty_base >> i));
            end
        end
    end

endmodule

// File: doc/led_pwm_breather.md
Name: led_pwm_breather

Overview:
- Downstream consumer of the free-running prescaler counter in the icestick board designs.
- Takes the counter's single-cycle carry strobe and turns it into a breathing (triangle-ramped PWM) brightness pattern on the board LEDs.
- Replaces the raw MSB-to-LED hookup with glitch-free duty-cycle control.

Parameters:
- PWM_BITS, 8, width of the PWM counter and brightness level; PWM period = 2^PWM_BITS cycles; MAX = 2^PWM_BITS-1.
- STEP_DIV, 4, number of TICK strobes per brightness step; must be >= 1.
- HOLD_STEPS, 8, number of steps spent at full and at zero brightness; must be >= 1.
- NUM_LEDS, 5, number of LED outputs.

Ports:
- CLK  input  1  Clock, rising edge.
- RESETB  input  1  Asynchronous active-low reset.
- TICK  input  1  Single-cycle strobe from the upstream counter carry-out.
- EN  input  1  Run enable.
- D  output  NUM_LEDS  LED drives, active high.
- LEVEL  output  PWM_BITS  Current brightness level.
- PHASE  output  1  1 in RAMP_UP or HOLD_HI; 0 otherwise.

Behaviour:
- Clocking and reset: one clock (CLK); reset is asynchronous and active-low (RESETB).
- Reset values: pwm_cnt=0, div_cnt=0, hold_cnt=0, step_pending=0, state=RAMP_UP, LEVEL=0, D=0, PHASE=1.
- pwm_cnt:
  - Increments by 1 every cycle while EN=1; wraps MAX->0.
  - "Period end" is the cycle where pwm_cnt==MAX and EN=1.
- Step generation:
  - Each TICK with EN=1 advances div_cnt.
  - When div_cnt==STEP_DIV-1 on a TICK, div_cnt returns to 0 and step_pending is set.
  - step_pending is a flag, not a count: extra steps before it is consumed are dropped.
- Step application:
  - Only at period end with step_pending=1. The FSM advances and step_pending clears.
  - A TICK that would set step_pending in that same cycle re-sets it; the new step waits for the next period end.
  - The new LEVEL takes effect from pwm_cnt=0 of the next period, so the duty cycle never changes mid-period.
- FSM (one transition per applied step):
  - RAMP_UP: LEVEL+1; when the new LEVEL==MAX, go to HOLD_HI with hold_cnt=0.
  - HOLD_HI: hold_cnt+1; when hold_cnt==HOLD_STEPS-1, go to RAMP_DOWN.
  - RAMP_DOWN: LEVEL-1; when the new LEVEL==0, go to HOLD_LO with hold_cnt=0.
  - HOLD_LO: hold_cnt+1; when hold_cnt==HOLD_STEPS-1, go to RAMP_UP.
  - LEVEL never wraps.
- Duty computation:
  - Per-LED duty: duty_i = LEVEL >> i (LED 0 brightest).
  - D[i] is registered: D[i](t+1) = EN(t) & (pwm_cnt(t) < duty_i).
  - Latency from pwm_cnt to D is one cycle.
  - duty_i=0 gives D[i] constantly 0.
  - duty_i=MAX gives D[i] high for MAX of every 2^PWM_BITS cycles (low for the single pwm_cnt==MAX cycle).
- EN=0:
  - pwm_cnt forced to 0 and D forced to 0 on the next edge.
  - TICK is ignored; div_cnt, step_pending, state, LEVEL and hold_cnt are retained.
  - Resuming EN=1 restarts the period at pwm_cnt=0.
- Reset mid-operation: all state returns to reset values immediately; operation resumes from RAMP_UP, LEVEL=0.

Optional Feature:
- Macro: LED_PWM_BREATHER_GAMMA_EN.
- Defined: duty_i = ((LEVEL*LEVEL) >> PWM_BITS) >> i, giving a perceptual gamma ~2 ramp. The square is computed combinationally from registered LEVEL, so D latency is unchanged. LEVEL=MAX gives a base duty of MAX-1.
- Undefined: linear duty as above; no multiplier is instantiated.

Test Plan:
- All scenarios use PWM_BITS=4, STEP_DIV=2, HOLD_STEPS=2, NUM_LEDS=2 unless noted; the period is 16 cycles.
- Reset: hold RESETB=0 while toggling TICK/EN -> D=0, LEVEL=0, PHASE=1. Release RESETB with EN=1 and no TICK for 64 cycles -> D stays 0, LEVEL stays 0.
- Step divider / period alignment:
  - Pulse TICK twice early in a period -> LEVEL becomes 1 only at the following pwm_cnt=0.
  - In the next period, D[0] is high for exactly 1 cycle and D[1] stays 0.
  - Four TICKs within one period -> LEVEL advances by only 1.
- Full breathing cycle: TICK every 16 cycles -> LEVEL ramps 0..15, holds 15 for 2 steps (PHASE=1), ramps 15..0 (PHASE=0), holds 0 for 2 steps, then returns to RAMP_UP. That is 34 steps / 68 TICKs total.
- Duty extremes at LEVEL=15:
  - D[0] high 15 of 16 cycles.
  - D[1] (duty 7) high 7 of 16 cycles.
  - Low cycle of D[0] falls one cycle after pwm_cnt==15.
- EN gating: drop EN mid-period with LEVEL=9 and pulse TICK 4 times -> D=0 next edge, LEVEL stays 9, div_cnt unchanged. Raise EN -> pwm_cnt restarts at 0.
- Async reset mid-ramp: assert RESETB off-edge at LEVEL=6 in RAMP_DOWN -> outputs are reset values immediately, without waiting for a clock edge.
- GAMMA build (LED_PWM_BREATHER_GAMMA_EN defined): LEVEL=8 -> D[0] high 4 of 16 cycles; LEVEL=15 -> D[0] high 14 of 16 cycles.
